// File: rtl/imem_loader_if.sv
// Loader bus: control inputs, UART byte stream and the instruction memory write port.
// The master side drives start and the received bytes; the slave side is the loader.
interface imem_loader_if #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output start, rx_valid, rx_data,
    input  wr_en, wr_addr, wr_data, cpu_hold, busy, done, err, err_code
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output wr_en, wr_addr, wr_data, cpu_hold, busy, done, err, err_code
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. Frames a UART byte stream
// (SYNC, COUNT, 4*COUNT big-endian data bytes, XOR checksum), writes each word to the
// instruction memory and keeps the CPU in reset until a verified image is in place.
module imem_loader #(
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned ADDR_W         = 5,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic            i_clk,
  input logic            i_reset,
  imem_loader_if.slave   io_bus
);

  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWaitSync = 3'd1;
  localparam logic [2:0] StGetCount = 3'd2;
  localparam logic [2:0] StGetData  = 3'd3;
  localparam logic [2:0] StGetCsum  = 3'd4;
  localparam logic [2:0] StDone     = 3'd5;
  localparam logic [2:0] StError    = 3'd6;

  logic [2:0]        r_state;
  logic [ADDR_W:0]   r_count;     // one extra bit so COUNT=DEPTH is representable
  logic [1:0]        r_byte_cnt;
  logic [ADDR_W-1:0] r_word_idx;
  logic [WORD_W-9:0] r_shift;     // first three bytes of the word being assembled
  logic [7:0]        r_csum;
  logic [IdleW-1:0]  r_idle;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [WORD_W-1:0] r_wr_data;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_err;
  logic [1:0]        r_err_code;

  logic              w_in_frame;
  logic              w_timeout;
  logic              w_bad_count;
  logic              w_last_word;
  logic [WORD_W-1:0] w_word;

  // Frame-phase decode, timeout detection and word assembly.
  always_comb begin
    w_in_frame  = (r_state == StGetCount) || (r_state == StGetData) || (r_state == StGetCsum);
    // A byte arriving on the expiring cycle wins over the timeout.
    w_timeout   = w_in_frame && !io_bus.rx_valid && (r_idle == IdleW'(TIMEOUT_CYCLES - 1));
    w_bad_count = (io_bus.rx_data == 8'd0) || (32'(io_bus.rx_data) > DEPTH);
    w_last_word = ({1'b0, r_word_idx} == (r_count - 1'b1));
    w_word      = {r_shift, io_bus.rx_data};
  end

  // Loader state machine, counters, checksum and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_count    <= '0;
      r_byte_cnt <= '0;
      r_word_idx <= '0;
      r_shift    <= '0;
      r_csum     <= '0;
      r_idle     <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_timeout) begin
        r_state    <= StError;
        r_err      <= 1'b1;
        r_err_code <= 2'd3;
        r_idle     <= '0;
      end else begin
        if (w_in_frame) begin
          r_idle <= io_bus.rx_valid ? '0 : r_idle + 1'b1;
        end
        case (r_state)
          StIdle, StDone, StError: begin
            if (io_bus.start) begin
              r_state    <= StWaitSync;
              r_cpu_hold <= 1'b1;
              r_done     <= 1'b0;
              r_err      <= 1'b0;
              r_err_code <= 2'd0;
              r_count    <= '0;
              r_byte_cnt <= '0;
              r_word_idx <= '0;
              r_shift    <= '0;
              r_csum     <= '0;
              r_idle     <= '0;
            end
          end
          StWaitSync: begin
            if (io_bus.rx_valid && (io_bus.rx_data == SYNC_BYTE)) begin
              r_state <= StGetCount;
            end
          end
          StGetCount: begin
            if (io_bus.rx_valid) begin
              if (w_bad_count) begin
                r_state    <= StError;
                r_err      <= 1'b1;
                r_err_code <= 2'd1;
              end else begin
                r_count <= io_bus.rx_data[ADDR_W:0];
                r_state <= StGetData;
              end
            end
          end
          StGetData: begin
            if (io_bus.rx_valid) begin
              r_shift    <= w_word[WORD_W-9:0];
              r_csum     <= r_csum ^ io_bus.rx_data;
              r_byte_cnt <= r_byte_cnt + 1'b1;
              if (r_byte_cnt == 2'd3) begin
                r_wr_en    <= 1'b1;
                r_wr_addr  <= r_word_idx;
                r_wr_data  <= w_word;
                r_word_idx <= r_word_idx + 1'b1;
                if (w_last_word) begin
                  r_state <= StGetCsum;
                end
              end
            end
          end
          StGetCsum: begin
            if (io_bus.rx_valid) begin
              if (io_bus.rx_data == r_csum) begin
                r_state    <= StDone;
                r_done     <= 1'b1;
                r_cpu_hold <= 1'b0;
              end else begin
                r_state    <= StError;
                r_err      <= 1'b1;
                r_err_code <= 2'd2;
              end
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign io_bus.wr_en    = r_wr_en;
  assign io_bus.wr_addr  = r_wr_addr;
  assign io_bus.wr_data  = r_wr_data;
  assign io_bus.cpu_hold = r_cpu_hold;
  assign io_bus.busy     = w_in_frame || (r_state == StWaitSync);
  assign io_bus.done     = r_done;
  assign io_bus.err      = r_err;
  assign io_bus.err_code = r_err_code;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good frame, bad checksum, bad count, timeout edge,
// noise, ignored start, back-to-back bytes and reset mid-frame.
module tb_imem_loader;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0]  q_addr[$];
  logic [31:0] q_data[$];

  imem_loader_if #(.WORD_W(32), .ADDR_W(5)) bus ();

  imem_loader #(
    .WORD_W(32),
    .DEPTH(32),
    .ADDR_W(5),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      q_addr.push_back(bus.wr_addr);
      q_data.push_back(bus.wr_data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_burst4(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = w[i*8 +: 8];
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset        = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_wr_en", bus.wr_en, 1'b0);
    check("rst_wr_addr", bus.wr_addr, 5'd0);
    check("rst_wr_data", bus.wr_data, 32'h0);
    check("rst_cpu_hold", bus.cpu_hold, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_err_code", bus.err_code, 2'd0);
    reset = 1'b0;

    // Good frame with leading noise, back-to-back first word, stray start mid-frame
    pulse_start();
    check("arm_busy", bus.busy, 1'b1);
    check("arm_cpu_hold", bus.cpu_hold, 1'b1);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check("noise_busy", bus.busy, 1'b1);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_burst4(32'h012A4020);
    check("b2b_wr_en", bus.wr_en, 1'b1);
    check("b2b_wr_addr", bus.wr_addr, 5'd0);
    check("b2b_wr_data", bus.wr_data, 32'h012A4020);
    pulse_start();
    check("ign_start_busy", bus.busy, 1'b1);
    send_word(32'h018D5822);
    send_byte(8'hBD);
    check("good_done", bus.done, 1'b1);
    check("good_cpu_hold", bus.cpu_hold, 1'b0);
    check("good_err", bus.err, 1'b0);
    check("good_busy", bus.busy, 1'b0);
    check("good_nwr", q_addr.size(), 2);
    if (q_addr.size() == 2) begin
      check("good_addr0", q_addr[0], 5'd0);
      check("good_data0", q_data[0], 32'h012A4020);
      check("good_addr1", q_addr[1], 5'd1);
      check("good_data1", q_data[1], 32'h018D5822);
    end

    // Bad checksum
    q_addr.delete();
    q_data.delete();
    pulse_start();
    check("csum_arm_done", bus.done, 1'b0);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_word(32'h012A4020);
    send_word(32'h018D5822);
    send_byte(8'h42);
    check("csum_nwr", q_addr.size(), 2);
    check("csum_err", bus.err, 1'b1);
    check("csum_code", bus.err_code, 2'd2);
    check("csum_hold", bus.cpu_hold, 1'b1);
    check("csum_done", bus.done, 1'b0);

    // Bad count: zero, then DEPTH+1
    q_addr.delete();
    q_data.delete();
    pulse_start();
    check("start_clr_err", bus.err, 1'b0);
    send_byte(8'hA5);
    send_byte(8'h00);
    check("cnt0_err", bus.err, 1'b1);
    check("cnt0_code", bus.err_code, 2'd1);
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h21);
    check("cnt33_code", bus.err_code, 2'd1);
    check("cnt33_hold", bus.cpu_hold, 1'b1);
    send_byte(8'hA5);
    check("err_ignores_rx", bus.busy, 1'b0);
    check("cnt_nwr", q_addr.size(), 0);

    // Timeout expires exactly 100 idle cycles after the last byte
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    repeat (99) @(negedge clk);
    check("to_99_err", bus.err, 1'b0);
    @(negedge clk);
    check("to_100_err", bus.err, 1'b1);
    check("to_100_code", bus.err_code, 2'd3);

    // A byte on the 100th idle cycle keeps the load alive
    q_addr.delete();
    q_data.delete();
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    repeat (99) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h34;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check("alive_err", bus.err, 1'b0);
    check("alive_busy", bus.busy, 1'b1);
    send_byte(8'h56);
    send_byte(8'h78);
    send_byte(8'h08);
    check("alive_done", bus.done, 1'b1);
    check("alive_nwr", q_addr.size(), 1);
    if (q_data.size() == 1) check("alive_data", q_data[0], 32'h12345678);

    // Reset in the middle of a data word
    q_addr.delete();
    q_data.delete();
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'hDE);
    send_byte(8'hAD);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check("mrst_hold", bus.cpu_hold, 1'b0);
    check("mrst_busy", bus.busy, 1'b0);
    check("mrst_addr", bus.wr_addr, 5'd0);
    check("mrst_data", bus.wr_data, 32'h0);
    check("mrst_done", bus.done, 1'b0);
    check("mrst_err", bus.err, 1'b0);
    send_byte(8'hBE);
    send_byte(8'hEF);
    repeat (3) @(negedge clk);
    check("mrst_nwr", q_addr.size(), 0);
    check("mrst_idle_busy", bus.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time program loader that writes 32-bit instructions into the instruction memory's write port. It takes a byte stream from the UART receiver, frames and checks it, and holds the CPU in reset while loading. It releases the CPU only after a complete, checksum-verified image has been written.

Parameters:
WORD_W, 32, instruction width in bits; fixed at 32 (4 bytes/word).
DEPTH, 32, number of instruction memory words.
ADDR_W, 5, width of the write address (log2 DEPTH).
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CYCLES, 1000000, maximum idle cycles allowed between bytes inside a frame.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; returns the block to IDLE
start  in  1  one-cycle pulse that arms the loader
rx_valid  in  1  one-cycle strobe: rx_data holds a new byte
rx_data  in  8  received byte
wr_en  out  1  instruction memory write strobe, one cycle per word
wr_addr  out  ADDR_W  word index being written
wr_data  out  WORD_W  assembled instruction word
cpu_hold  out  1  holds the CPU in reset while high
busy  out  1  high in WAIT_SYNC, GET_COUNT, GET_DATA and GET_CSUM
done  out  1  sticky; last load succeeded
err  out  1  sticky; last load failed
err_code  out  2  error cause: 0 none, 1 bad count, 2 checksum, 3 timeout

Behaviour:
- Reset values: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, busy=0, done=0, err=0, err_code=0. All internal counters and the checksum clear. Reset mid-frame aborts the load; memory contents already written are left as they are.
- Frame format: SYNC_BYTE, COUNT (number of words, 1..DEPTH), then 4*COUNT data bytes, then CSUM.
  - Data bytes are big-endian; the first byte goes to wr_data[31:24].
  - CSUM = XOR of all data bytes.
- FSM states: IDLE, WAIT_SYNC, GET_COUNT, GET_DATA, GET_CSUM, DONE, ERROR.
- IDLE/DONE/ERROR + start: go to WAIT_SYNC.
  - cpu_hold=1; done, err, err_code clear.
  - Byte counter, word counter and checksum clear.
- start is ignored while busy=1.
- WAIT_SYNC: a byte equal to SYNC_BYTE moves to GET_COUNT; any other byte is discarded. No timeout applies in this state.
- GET_COUNT:
  - COUNT=0 or COUNT>DEPTH: go to ERROR with err_code=1.
  - Otherwise latch COUNT and go to GET_DATA.
- GET_DATA:
  - Each byte shifts into the word register and is XORed into the checksum.
  - On the 4th byte of a word, wr_en=1 for exactly the following cycle, with wr_addr = word index and wr_data = full word. The word index then increments.
  - After word COUNT-1 is written, go to GET_CSUM.
- GET_CSUM:
  - Match: go to DONE; done=1, cpu_hold=0 on the same edge the state changes.
  - Mismatch: go to ERROR with err_code=2.
  - Words already written are not rolled back.
- Timeout: in GET_COUNT, GET_DATA and GET_CSUM, an idle counter increments every cycle without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT_CYCLES goes to ERROR with err_code=3.
  - If rx_valid arrives in the same cycle the counter would expire, the byte is accepted and no timeout occurs.
- ERROR: err=1, cpu_hold stays 1. The state persists until start or reset.
- rx_valid in IDLE, DONE or ERROR is ignored.
- Write timing: wr_en is a registered pulse one cycle after the 4th byte's rx_valid. wr_addr and wr_data are stable while wr_en=1. Consecutive rx_valid strobes on back-to-back cycles must be accepted without loss.
- wr_addr never exceeds DEPTH-1.

Test Plan:
- Good frame: start; bytes A5,02, then 01 2A 40 20 and 01 8D 58 22, then CSUM=XOR of the 8 data bytes -> two wr_en pulses: addr 0 = 32'h012A4020, addr 1 = 32'h018D5822; then done=1, cpu_hold=0, err=0.
- Bad checksum: same frame with CSUM flipped -> both words written; err=1, err_code=2, cpu_hold=1, done=0.
- Bad count: A5,00 -> ERROR, err_code=1, no wr_en. Repeat with A5,21 (33 > DEPTH=32) -> err_code=1, no wr_en.
- Timeout (TIMEOUT_CYCLES=100 for sim): A5,01,12 then silence -> err_code=3 exactly 100 cycles after the last byte. Separately, a byte on the 100th idle cycle keeps the load alive.
- Noise and ignored start: bytes 00,FF,5A before A5 are discarded. A start pulse mid-frame is ignored. Back-to-back rx_valid on 4 consecutive cycles yields one correct word.
- Reset mid-frame: assert reset during GET_DATA -> next cycle all outputs at reset values, cpu_hold=0, no further wr_en.
